// File: rtl/region_scheduler_if.sv
// Request, dispatch and reconfiguration signals between the metadata queue,
// the region fabric and the region scheduler.
`default_nettype none

interface region_scheduler_if #(
  parameter int HTTP_DATA_WIDTH = 8,
  parameter int N_REGIONS       = 4,
  parameter int STAT_WIDTH      = 16,
  parameter int FID_WIDTH       = 4
) ();
  localparam int REGION_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic                            req_tvalid;
  logic                            req_tready;
  logic [HTTP_DATA_WIDTH-1:0]      req_tdata;
  logic [N_REGIONS*STAT_WIDTH-1:0] region_stats_in;
  logic                            disp_valid;
  logic                            disp_ready;
  logic [REGION_W-1:0]             disp_region;
  logic [HTTP_DATA_WIDTH-1:0]      disp_data;
  logic                            pr_req;
  logic [REGION_W-1:0]             pr_region;
  logic [FID_WIDTH-1:0]            pr_fid;
  logic                            pr_done;
  logic [31:0]                     lb_ctrl;

  modport slave (
    input  req_tvalid, req_tdata, region_stats_in, disp_ready, pr_done,
    output req_tready, disp_valid, disp_region, disp_data,
           pr_req, pr_region, pr_fid, lb_ctrl
  );

  modport master (
    output req_tvalid, req_tdata, region_stats_in, disp_ready, pr_done,
    input  req_tready, disp_valid, disp_region, disp_data,
           pr_req, pr_region, pr_fid, lb_ctrl
  );
endinterface

`default_nettype wire

// File: rtl/region_scheduler.sv
// region_scheduler: pops one request, picks the least-loaded region that holds
// the function (or reconfigures the least-loaded available one), then dispatches.
`default_nettype none

module region_scheduler #(
  parameter int HTTP_DATA_WIDTH = 8,
  parameter int N_REGIONS       = 4,
  parameter int STAT_WIDTH      = 16,
  parameter int FID_WIDTH       = 4
) (
  input  wire logic          aclk,
  input  wire logic          aresetn,
  region_scheduler_if.slave  bus
);
  localparam int REGION_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    RECONF   = 2'd2,
    DISPATCH = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [HTTP_DATA_WIDTH-1:0] data_q, data_d;
  logic [REGION_W-1:0]        target_q, target_d;
  logic [FID_WIDTH-1:0]       fid_tab_q [N_REGIONS];
  logic [FID_WIDTH-1:0]       fid_tab_d [N_REGIONS];
  logic [N_REGIONS-1:0]       fid_valid_q, fid_valid_d;
  logic [15:0]                disp_cnt_q, disp_cnt_d;
  logic [REGION_W-1:0]        last_region_q, last_region_d;
  logic [31:0]                lb_ctrl_q, lb_ctrl_d;
  logic                       alive_q, alive_d;

  logic [FID_WIDTH-1:0]       w_fid;
  logic                       hit_any, elig_any;
  logic [REGION_W-1:0]        hit_idx, elig_idx;
  logic [STAT_WIDTH-1:0]      hit_load, elig_load;
  logic [7:0]                 last_ext;

  assign w_fid = data_q[FID_WIDTH-1:0];

  // Strict less-than keeps the lowest index on equal loads.
  always_comb begin : arb_pick
    logic [STAT_WIDTH-1:0] load_v;
    load_v    = '0;
    hit_any   = 1'b0;
    hit_idx   = '0;
    hit_load  = '1;
    elig_any  = 1'b0;
    elig_idx  = '0;
    elig_load = '1;
    for (int i = 0; i < N_REGIONS; i++) begin
      load_v = bus.region_stats_in[i*STAT_WIDTH +: STAT_WIDTH];
      if (load_v != '1) begin
        if (!elig_any || (load_v < elig_load)) begin
          elig_any  = 1'b1;
          elig_load = load_v;
          elig_idx  = REGION_W'(i);
        end
        if (fid_valid_q[i] && (fid_tab_q[i] == w_fid) &&
            (!hit_any || (load_v < hit_load))) begin
          hit_any  = 1'b1;
          hit_load = load_v;
          hit_idx  = REGION_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    target_d      = target_q;
    fid_tab_d     = fid_tab_q;
    fid_valid_d   = fid_valid_q;
    disp_cnt_d    = disp_cnt_q;
    last_region_d = last_region_q;
    alive_d       = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.req_tvalid && alive_q) begin
          data_d  = bus.req_tdata;
          state_d = ARB;
        end
      end
      ARB: begin
        if (hit_any) begin
          target_d = hit_idx;
          state_d  = DISPATCH;
        end else if (elig_any) begin
          target_d = elig_idx;
          state_d  = RECONF;
        end
      end
      RECONF: begin
        if (bus.pr_done) begin
          for (int i = 0; i < N_REGIONS; i++) begin
            if (REGION_W'(i) == target_q) begin
              fid_tab_d[i]   = w_fid;
              fid_valid_d[i] = 1'b1;
            end
          end
          state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        if (bus.disp_ready) begin
          disp_cnt_d    = disp_cnt_q + 16'd1;
          last_region_d = target_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_ext                 = '0;
    last_ext[REGION_W-1:0]   = last_region_q;
    lb_ctrl_d = {4'b0001 << state_q, 4'b0000, last_ext, disp_cnt_q};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      data_q        <= '0;
      target_q      <= '0;
      fid_valid_q   <= '0;
      disp_cnt_q    <= '0;
      last_region_q <= '0;
      lb_ctrl_q     <= '0;
      alive_q       <= 1'b0;
      for (int i = 0; i < N_REGIONS; i++) fid_tab_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      target_q      <= target_d;
      fid_valid_q   <= fid_valid_d;
      disp_cnt_q    <= disp_cnt_d;
      last_region_q <= last_region_d;
      lb_ctrl_q     <= lb_ctrl_d;
      alive_q       <= alive_d;
      for (int i = 0; i < N_REGIONS; i++) fid_tab_q[i] <= fid_tab_d[i];
    end
  end

  // alive_q keeps ready low while reset is held and for the first edge after.
  assign bus.req_tready  = alive_q && (state_q == IDLE);
  assign bus.disp_valid  = (state_q == DISPATCH);
  assign bus.pr_req      = (state_q == RECONF);
  assign bus.disp_region = target_q;
  assign bus.pr_region   = target_q;
  assign bus.disp_data   = data_q;
  assign bus.pr_fid      = w_fid;
  assign bus.lb_ctrl     = lb_ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_region_scheduler.sv
// Randomized bench for region_scheduler with a transaction-level reference model.
`default_nettype none

module tb_region_scheduler;
  localparam int HW = 8;
  localparam int NR = 4;
  localparam int SW = 16;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  region_scheduler_if #(.HTTP_DATA_WIDTH(HW), .N_REGIONS(NR), .STAT_WIDTH(SW), .FID_WIDTH(FW)) bus ();

  region_scheduler #(.HTTP_DATA_WIDTH(HW), .N_REGIONS(NR), .STAT_WIDTH(SW), .FID_WIDTH(FW)) dut (
    .aclk    (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: function table, expected phase (0 idle,1 arb,2 reconf,3 dispatch).
  logic [FW-1:0] m_tab [NR];
  bit            m_valid [NR];
  int            phase;
  int            exp_region;
  logic [HW-1:0] exp_data;
  int            exp_cnt;
  int            exp_last;
  bit            rdy_known;
  logic [31:0]   prev_lb = '0;

  function automatic void reset_model();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_tab[i]   = '0;
    end
    phase     = 0;
    exp_cnt   = 0;
    exp_last  = 0;
    exp_region = 0;
    exp_data  = '0;
    rdy_known = 1'b0;
  endfunction

  function automatic void pick(input logic [NR*SW-1:0] st, input logic [FW-1:0] fid,
                               output bit found, output bit need_pr, output int reg_o);
    int best_hit = -1;
    int best_el  = -1;
    logic [SW-1:0] ld;
    for (int i = 0; i < NR; i++) begin
      ld = st[i*SW +: SW];
      if (ld != 16'hFFFF) begin
        if (best_el < 0 || ld < st[best_el*SW +: SW]) best_el = i;
        if (m_valid[i] && m_tab[i] == fid && (best_hit < 0 || ld < st[best_hit*SW +: SW]))
          best_hit = i;
      end
    end
    found   = (best_el >= 0);
    need_pr = (best_hit < 0) && found;
    reg_o   = (best_hit >= 0) ? best_hit : ((best_el >= 0) ? best_el : 0);
  endfunction

  function automatic logic [NR*SW-1:0] rand_stats();
    logic [NR*SW-1:0] s;
    bit any = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(5) == 0) s[i*SW +: SW] = 16'hFFFF;
      else begin
        s[i*SW +: SW] = 16'($urandom_range(3));
        any = 1'b1;
      end
    end
    if (!any) s[SW-1:0] = 16'h0007;
    return s;
  endfunction

  // Per-cycle comparison against the model's expected phase and values.
  always @(negedge clk) begin : compare
    logic [3:0] oh;
    if (!aresetn) begin
      check("rst_req_tready", bus.req_tready, 0);
      check("rst_disp_valid", bus.disp_valid, 0);
      check("rst_pr_req", bus.pr_req, 0);
      check("rst_disp_region", bus.disp_region, 0);
      check("rst_pr_fid", bus.pr_fid, 0);
      check("rst_lb_ctrl", bus.lb_ctrl, 0);
      prev_lb = '0;
    end else begin
      check("pr_req", bus.pr_req, phase == 2);
      check("disp_valid", bus.disp_valid, phase == 3);
      if (rdy_known) check("req_tready", bus.req_tready, phase == 0);
      if (phase == 2) begin
        check("pr_region", bus.pr_region, exp_region);
        check("pr_fid", bus.pr_fid, exp_data[FW-1:0]);
      end
      if (phase == 3) begin
        check("disp_region", bus.disp_region, exp_region);
        check("disp_data", bus.disp_data, exp_data);
      end
      check("lb_ctrl", bus.lb_ctrl, prev_lb);
      oh = 4'b0001 << phase;
      prev_lb = {oh, 4'h0, 8'(exp_last), 16'(exp_cnt)};
    end
  end

  // Issues one request (called in an idle cycle, just after a rising edge).
  task automatic run_req(input logic [HW-1:0] data, input logic [NR*SW-1:0] stats,
                         input int unavail, input int pr_lat, input int rdy_lat,
                         input bit abort, output int reg_o, output bit pr_o);
    bit found = 1'b0;
    int waited = 0;
    bus.req_tdata       = data;
    bus.req_tvalid      = 1'b1;
    bus.region_stats_in = (unavail > 0) ? '1 : stats;
    @(posedge clk); #1;
    bus.req_tvalid = 1'b0;
    bus.req_tdata  = HW'($urandom);
    phase    = 1;
    exp_data = data;
    while (!found) begin
      pick(bus.region_stats_in, data[FW-1:0], found, pr_o, reg_o);
      @(posedge clk); #1;
      if (!found) begin
        waited++;
        if (waited >= unavail) bus.region_stats_in = stats;
      end
    end
    exp_region = reg_o;
    bus.region_stats_in = {$urandom, $urandom};
    if (pr_o) begin
      phase = 2;
      if (abort) begin
        @(posedge clk); #1;
        aresetn = 1'b0;
        #1;
        check("abort_pr_req", bus.pr_req, 0);
        check("abort_disp_valid", bus.disp_valid, 0);
        reset_model();
        repeat (2) begin @(posedge clk); #1; end
        aresetn = 1'b1;
        @(posedge clk); #1;
        rdy_known = 1'b1;
        return;
      end
      repeat (pr_lat) begin @(posedge clk); #1; end
      bus.pr_done = 1'b1;
      @(posedge clk); #1;
      bus.pr_done = 1'b0;
      m_tab[reg_o]   = data[FW-1:0];
      m_valid[reg_o] = 1'b1;
    end
    phase = 3;
    repeat (rdy_lat) begin
      bus.pr_done = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    bus.pr_done    = 1'b0;
    bus.disp_ready = 1'b1;
    @(posedge clk); #1;
    bus.disp_ready = 1'b0;
    exp_cnt  = (exp_cnt + 1) & 16'hFFFF;
    exp_last = reg_o;
    phase    = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  r;
    bit  p;
    aresetn             = 1'b0;
    bus.req_tvalid      = 1'b0;
    bus.req_tdata       = '0;
    bus.region_stats_in = '0;
    bus.disp_ready      = 1'b0;
    bus.pr_done         = 1'b0;
    reset_model();
    repeat (3) begin @(posedge clk); #1; end
    aresetn = 1'b1;
    @(posedge clk); #1;
    rdy_known = 1'b1;

    // Miss on an empty table: region 0 has the lowest load.
    run_req(8'h02, 64'h0004_0003_0002_0001, 0, 2, 0, 1'b0, r, p);
    check("t1_pr", p, 1);
    check("t1_region", r, 0);
    @(posedge clk); #1;
    check("t1_lb_ctrl", bus.lb_ctrl, 32'h1000_0001);

    run_req(8'hA2, 64'h0005_0005_0005_0001, 0, 0, 0, 1'b0, r, p);
    check("t2_pr", p, 0);
    check("t2_region", r, 0);

    run_req(8'h02, 64'h0009_0002_0002_FFFF, 0, 1, 0, 1'b0, r, p);
    check("t3_pr", p, 1);
    check("t3_region", r, 1);

    run_req(8'h05, 64'h0010_FFFF_FFFF_FFFF, 4, 0, 1, 1'b0, r, p);
    check("t4_pr", p, 1);
    check("t4_region", r, 3);

    run_req(8'h35, 64'h0001_0002_0003_0004, 0, 0, 5, 1'b0, r, p);
    check("t5_pr", p, 0);
    check("t5_region", r, 3);
    @(posedge clk); #1;
    check("t5_lb_ctrl", bus.lb_ctrl, 32'h1003_0005);

    for (int k = 0; k < 40; k++) begin
      run_req({4'($urandom), 4'($urandom_range(3))}, rand_stats(), 0,
              $urandom_range(3), $urandom_range(2), 1'b0, r, p);
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
    end

    run_req(8'h07, 64'h0001_0001_0001_0001, 0, 3, 0, 1'b1, r, p);
    @(negedge clk);
    check("t6_lb_after_reset", bus.lb_ctrl, 32'h1000_0000);
    @(posedge clk); #1;

    run_req(8'h02, 64'h0001_0001_0001_0001, 0, 0, 0, 1'b0, r, p);
    check("t6_table_cleared_pr", p, 1);
    check("t6_region", r, 0);
    @(posedge clk); #1;
    check("t6_lb_cnt", bus.lb_ctrl, 32'h1000_0001);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
